uart_tx_word: RTL and testbench

- Serialises one DATA_WIDTH-bit word onto a UART line as DATA_WIDTH/8 back-to-back 8N1 frames.
- Byte 0 (data_in[7:0]) goes first; within each frame, bit 0 goes first.
- Bit timing comes from the shared 16x oversample enable clken, the same enable that drives the word-assembling receiver at the other end of the link.
- Sits between a bus-side requester and the board-level tx pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_word.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_word.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and constants for the tx/rx word link.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } tx_state_e;

  localparam int   UART_TICKS_PER_BIT = 16;
  localparam logic UART_IDLE_LEVEL    = 1'b1;

  function automatic int uart_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_word.sv
// ============================================================================
// Module   : uart_tx_word
// Brief    : Sends one DATA_WIDTH word as DATA_WIDTH/8 back-to-back 8N1 frames,
//            byte 0 first, LSB first, timed by a shared 16x oversample enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_word
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT,
  parameter int GAP_TICKS     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int c_nbytes   = DATA_WIDTH / 8;
  localparam int c_tick_max = uart_max(uart_max(TICKS_PER_BIT, GAP_TICKS), 2);
  localparam int c_tick_w   = $clog2(c_tick_max);
  localparam int c_byte_w   = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;

  localparam logic [c_tick_w-1:0] c_bit_last  = c_tick_w'(TICKS_PER_BIT - 1);
  localparam logic [c_tick_w-1:0] c_gap_last  = c_tick_w'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(c_nbytes - 1);

  tx_state_e             r_state,    w_state;
  logic [c_tick_w-1:0]   r_tick_cnt, w_tick_cnt;
  logic [2:0]            r_bit_idx,  w_bit_idx;
  logic [c_byte_w-1:0]   r_byte_idx, w_byte_idx;
  logic [DATA_WIDTH-1:0] r_shreg,    w_shreg;
  logic                  r_tx,       w_tx;
  logic                  r_in_ready, w_in_ready;
  logic                  r_busy,     w_busy;
  logic                  r_done,     w_done;
  logic                  w_frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shreg    <= '0;
      r_tx       <= UART_IDLE_LEVEL;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick_cnt <= w_tick_cnt;
      r_bit_idx  <= w_bit_idx;
      r_byte_idx <= w_byte_idx;
      r_shreg    <= w_shreg;
      r_tx       <= w_tx;
      r_in_ready <= w_in_ready;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_tick_cnt  = r_tick_cnt;
    w_bit_idx   = r_bit_idx;
    w_byte_idx  = r_byte_idx;
    w_shreg     = r_shreg;
    w_in_ready  = r_in_ready;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_frame_end = 1'b0;

    case (r_state)
      IDLE: begin
        // Acceptance ignores clken, so the first start bit may run slightly long.
        if (in_valid && r_in_ready) begin
          w_shreg    = data_in;
          w_in_ready = 1'b0;
          w_busy     = 1'b1;
          w_state    = START;
          w_tick_cnt = '0;
          w_byte_idx = '0;
        end
      end
      START: begin
        if (clken) begin
          if (r_tick_cnt == c_bit_last) begin
            w_tick_cnt = '0;
            w_bit_idx  = '0;
            w_state    = DATA;
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (clken) begin
          if (r_tick_cnt == c_bit_last) begin
            w_tick_cnt = '0;
            w_shreg    = {1'b0, r_shreg[DATA_WIDTH-1:1]};
            w_bit_idx  = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              w_state = STOP;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (clken) begin
          if (r_tick_cnt == c_bit_last) begin
            w_tick_cnt = '0;
            if (GAP_TICKS == 0) begin
              w_frame_end = 1'b1;
            end else begin
              w_state = GAP;
            end
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (clken) begin
          if (r_tick_cnt == c_gap_last) begin
            w_tick_cnt  = '0;
            w_frame_end = 1'b1;
          end else begin
            w_tick_cnt = r_tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state    = IDLE;
        w_tick_cnt = '0;
        w_bit_idx  = '0;
        w_byte_idx = '0;
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
      end
    endcase

    // After eight shifts the next byte already sits in shreg[7:0].
    if (w_frame_end) begin
      if (r_byte_idx == c_byte_last) begin
        w_state    = IDLE;
        w_busy     = 1'b0;
        w_in_ready = 1'b1;
        w_done     = 1'b1;
        w_byte_idx = '0;
      end else begin
        w_byte_idx = r_byte_idx + 1'b1;
        w_state    = START;
      end
    end

    case (w_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_shreg[0];
      default: w_tx = UART_IDLE_LEVEL;
    endcase
  end

  assign tx       = r_tx;
  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_word.sv
// ============================================================================
// Module   : tb_uart_tx_word
// Brief    : Scoreboard bench: loop-back 8N1 receiver model checks tx against
//            queued words; a done monitor checks latency and pulse width.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_word;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken = 1'b0;
  logic [31:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic        done;

  uart_tx_word #(
    .DATA_WIDTH   (32),
    .TICKS_PER_BIT(16),
    .GAP_TICKS    (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clken   (clken),
    .data_in (data_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic clken_en = 1'b1;
  int   div      = 0;
  int   tick_count = 0;

  // clken every 4th clk, changed just after the edge so the DUT sees it cleanly.
  always @(posedge clk) begin
    #1;
    div   = (div + 1) % 4;
    clken = clken_en && (div == 0);
  end

  always @(posedge clk) begin
    if (clken) tick_count++;
  end

  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Loop-back receiver model, centre-sampling on clken ticks.
  int          rx_state = 0;
  int          rx_t0 = 0;
  int          rx_next = 0;
  int          rx_bitn = 0;
  int          rx_nbytes = 0;
  int          rx_last_t0 = 0;
  bit          rx_have_last = 0;
  int          rx_words = 0;
  logic [7:0]  rx_byte;
  logic [31:0] rx_acc;
  logic [31:0] rx_word = '0;
  logic        prev_tx = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      rx_state     = 0;
      rx_nbytes    = 0;
      rx_have_last = 0;
      prev_tx      = 1'b1;
    end else begin
      if (rx_state == 0) begin
        if (prev_tx && !tx) begin
          if (rx_nbytes > 0) check("byte_spacing", tick_count - rx_t0, 176);
          else if (rx_have_last) check("word_gap_ge176", (tick_count - rx_last_t0) >= 176, 1);
          rx_t0    = tick_count;
          rx_next  = rx_t0 + 24;
          rx_bitn  = 0;
          rx_state = 1;
        end
      end else begin
        if (tx !== prev_tx) check("edge_align_16", (tick_count - rx_t0) % 16, 0);
        if (tick_count == rx_next) begin
          if (rx_bitn < 8) begin
            rx_byte[rx_bitn] = tx;
            rx_bitn++;
            rx_next += 16;
          end else begin
            check("stop_bit", tx, 1);
            rx_acc[rx_nbytes*8 +: 8] = rx_byte;
            rx_nbytes++;
            if (rx_nbytes == 4) begin
              rx_word      = rx_acc;
              rx_words++;
              rx_nbytes    = 0;
              rx_last_t0   = rx_t0;
              rx_have_last = 1;
            end
            rx_state = 0;
          end
        end
      end
      prev_tx = tx;
    end
  end

  // Done monitor: pops the scoreboard and checks word, latency and pulse width.
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  int          acc_tick  = 0;
  int          done_cnt  = 0;
  logic [31:0] exp_w;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && !prev_busy) acc_tick = tick_count;
      if (prev_done) check("done_one_clk", done, 0);
      if (done) begin
        done_cnt++;
        check("exp_queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("rx_word", rx_word, exp_w);
        end
        check("word_latency_ticks", tick_count - acc_tick, 704);
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic send(input logic [31:0] w, input bit hold);
    int n = 0;
    @(negedge clk);
    data_in  = w;
    in_valid = 1'b1;
    exp_q.push_back(w);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", done_cnt != start, 1);
  endtask

  task automatic wait_ticks(input int target);
    int n = 0;
    while (tick_count < target && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("tick_target_reached", tick_count >= target, 1);
  endtask

  initial begin
    int   bad;
    logic hold_tx;
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_1000clk", bad, 0);

    send(32'hA55A_0FF0, 1'b0);
    wait_done();

    send(32'h0000_0001, 1'b1);
    data_in = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFF);
    wait_done();
    @(negedge clk);
    check("b2b_accept_next_clk", {busy, in_ready}, 2'b10);
    in_valid = 1'b0;
    wait_done();

    send(32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    #1;
    wait_ticks(acc_tick + 2*176 + 16 + 40);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    send(32'h1234_5678, 1'b0);
    @(negedge clk);
    #1;
    wait_ticks(acc_tick + 16 + 40);
    clken_en = 1'b0;
    repeat (2) @(negedge clk);
    hold_tx = tx;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== hold_tx || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check("freeze_hold", bad, 0);
    clken_en = 1'b1;
    wait_done();

    repeat (20) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("words_received", rx_words, 4);
    check("done_count", done_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
